// File: rtl/rriot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rriot_pkg
// Description : Shared widths, reset values and default parameters for the
//               RRIOT pad-side port conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package rriot_pkg;

    localparam int          PORT_W              = 8;
    localparam logic [7:0]  IN_RESET_VAL        = 8'hFF;
    localparam int          DEFAULT_DB_CYCLES   = 10;
    localparam int          DEFAULT_SYNC_STAGES = 2;
    // PB5/PB6 carry the RRIOT chip selects and must not be delayed by debounce
    localparam logic [7:0]  CS_BITS_B           = 8'h60;

endpackage : rriot_pkg
`default_nettype wire

// File: rtl/rriot_port_conditioner_pin_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pin_conditioner
// Description : One input pin: multi-flop synchroniser followed by a
//               counting debouncer with a bypass input. Emits the debounced
//               level and a registered pulse on the edge that level moves.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pad,
    input  logic i_bypass,
    output logic o_level,
    output logic o_chg
);

    localparam int                 c_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic                   r_chg;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; resets high so an idle pad produces no event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
        end
    end

    // Debouncer: any agreeing sample restarts the count; bypass tracks s directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            if (i_bypass) begin
                r_level <= w_s;
                r_cnt   <= '0;
                r_chg   <= w_s ^ r_level;
            end else if (w_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= w_s;
                r_cnt   <= '0;
                r_chg   <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_level = r_level;
    assign o_chg   = r_chg;

endmodule : pin_conditioner
`default_nettype wire

// File: rtl/rriot_port_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : rriot_port_conditioner
// Description : Pad-side conditioning for the two RRIOT 8-bit ports.
//               Registers PAO/PBO/DDRx onto the pad drive lines and feeds
//               synchronised, debounced pad inputs back as PAI/PBI, with a
//               change strobe and per-bit change mask.
// Revision    : 1.0 - initial release
// ============================================================================
module rriot_port_conditioner
    import rriot_pkg::*;
#(
    parameter int                SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int                DB_CYCLES   = DEFAULT_DB_CYCLES,
    parameter logic [PORT_W-1:0] BYPASS_B    = CS_BITS_B
) (
    input  logic              phi2,
    input  logic              rst_n,
    input  logic [PORT_W-1:0] pa_pad_i,
    input  logic [PORT_W-1:0] pb_pad_i,
    input  logic [PORT_W-1:0] PAO,
    input  logic [PORT_W-1:0] DDRA,
    input  logic [PORT_W-1:0] PBO,
    input  logic [PORT_W-1:0] DDRB,
    output logic [PORT_W-1:0] pa_pad_o,
    output logic [PORT_W-1:0] pa_pad_oe,
    output logic [PORT_W-1:0] pb_pad_o,
    output logic [PORT_W-1:0] pb_pad_oe,
    output logic [PORT_W-1:0] PAI,
    output logic [PORT_W-1:0] PBI,
    input  logic              db_bypass,
    output logic              chg_strobe,
    output logic [2*PORT_W-1:0] chg_mask
);

    logic [PORT_W-1:0] r_pa_pad_o;
    logic [PORT_W-1:0] r_pa_pad_oe;
    logic [PORT_W-1:0] r_pb_pad_o;
    logic [PORT_W-1:0] r_pb_pad_oe;
    logic [PORT_W-1:0] w_pa_level;
    logic [PORT_W-1:0] w_pb_level;
    logic [PORT_W-1:0] w_pa_chg;
    logic [PORT_W-1:0] w_pb_chg;

    // Output path: one register stage from the RRIOT to the pads; all inputs at reset
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_pa_pad_o  <= '0;
            r_pa_pad_oe <= '0;
            r_pb_pad_o  <= '0;
            r_pb_pad_oe <= '0;
        end else begin
            r_pa_pad_o  <= PAO;
            r_pa_pad_oe <= DDRA;
            r_pb_pad_o  <= PBO;
            r_pb_pad_oe <= DDRB;
        end
    end

    assign pa_pad_o  = r_pa_pad_o;
    assign pa_pad_oe = r_pa_pad_oe;
    assign pb_pad_o  = r_pb_pad_o;
    assign pb_pad_oe = r_pb_pad_oe;

    // Input path: every pin is conditioned regardless of its direction bit
    for (genvar i = 0; i < PORT_W; i++) begin : g_pa_pin
        pin_conditioner #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_pin (
            .clk      (phi2),
            .rst_n    (rst_n),
            .i_pad    (pa_pad_i[i]),
            .i_bypass (db_bypass),
            .o_level  (w_pa_level[i]),
            .o_chg    (w_pa_chg[i])
        );
    end

    for (genvar i = 0; i < PORT_W; i++) begin : g_pb_pin
        pin_conditioner #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_pin (
            .clk      (phi2),
            .rst_n    (rst_n),
            .i_pad    (pb_pad_i[i]),
            .i_bypass (db_bypass | BYPASS_B[i]),
            .o_level  (w_pb_level[i]),
            .o_chg    (w_pb_chg[i])
        );
    end

    assign PAI = w_pa_level;
    assign PBI = w_pb_level;

    // Per-pin change pulses are already registered alongside the level, so the
    // strobe lines up with the first cycle PAI/PBI shows the new value
    assign chg_mask   = {w_pb_chg, w_pa_chg};
    assign chg_strobe = |chg_mask;

endmodule : rriot_port_conditioner
`default_nettype wire

// File: tb/tb_rriot_port_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_rriot_port_conditioner
// Description : Directed self-checking bench for rriot_port_conditioner.
//               Expected change events are queued with their due cycle and
//               matched against chg_strobe/chg_mask by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rriot_port_conditioner;

    logic        phi2;
    logic        rst_n;
    logic [7:0]  pa_pad_i, pb_pad_i;
    logic [7:0]  PAO, DDRA, PBO, DDRB;
    logic [7:0]  pa_pad_o, pa_pad_oe, pb_pad_o, pb_pad_oe;
    logic [7:0]  PAI, PBI;
    logic        db_bypass;
    logic        chg_strobe;
    logic [15:0] chg_mask;

    typedef struct {
        int unsigned cyc;
        logic [15:0] mask;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int          checks;
    int          errors;

    rriot_port_conditioner dut (
        .phi2       (phi2),
        .rst_n      (rst_n),
        .pa_pad_i   (pa_pad_i),
        .pb_pad_i   (pb_pad_i),
        .PAO        (PAO),
        .DDRA       (DDRA),
        .PBO        (PBO),
        .DDRB       (DDRB),
        .pa_pad_o   (pa_pad_o),
        .pa_pad_oe  (pa_pad_oe),
        .pb_pad_o   (pb_pad_o),
        .pb_pad_oe  (pb_pad_oe),
        .PAI        (PAI),
        .PBI        (PBI),
        .db_bypass  (db_bypass),
        .chg_strobe (chg_strobe),
        .chg_mask   (chg_mask)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    initial cyc = 0;
    always @(posedge phi2) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge phi2);
        #1;
    endtask

    task automatic expect_chg(input int unsigned due, input logic [15:0] mask);
        exp_t e;
        e.cyc  = due;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every strobe must match the oldest queued event, cycle and mask
    always @(negedge phi2) begin
        if (chg_strobe === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_strobe observed mask=%h cycle=%0d expected=no strobe",
                       chg_mask, cyc);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobe_mask", {16'h0, chg_mask}, {16'h0, e.mask});
            end
        end
    end

    initial begin
        int unsigned c0;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        pa_pad_i  = 8'hFF;
        pb_pad_i  = 8'hFF;
        PAO       = 8'hFF;
        DDRA      = 8'hFF;
        PBO       = 8'hFF;
        DDRB      = 8'hFF;
        db_bypass = 1'b0;

        // Reset state
        step(3);
        chk("rst_pa_pad_o",  pa_pad_o,  8'h00);
        chk("rst_pa_pad_oe", pa_pad_oe, 8'h00);
        chk("rst_pb_pad_o",  pb_pad_o,  8'h00);
        chk("rst_pb_pad_oe", pb_pad_oe, 8'h00);
        chk("rst_PAI",       PAI,       8'hFF);
        chk("rst_PBI",       PBI,       8'hFF);
        chk("rst_strobe",    chg_strobe, 1'b0);
        chk("rst_mask",      chg_mask,  16'h0000);
        #2 rst_n = 1'b1;
        step(50);
        chk("idle_PAI", PAI, 8'hFF);
        chk("idle_PBI", PBI, 8'hFF);
        chk("idle_no_events", exp_q.size(), 0);

        // Output path: one-edge latency
        PAO  = 8'hA5; DDRA = 8'hF0; PBO = 8'h3C; DDRB = 8'h0F;
        chk("out_pa_o_before", pa_pad_o, 8'hFF);
        step(1);
        chk("out_pa_o",  pa_pad_o,  8'hA5);
        chk("out_pa_oe", pa_pad_oe, 8'hF0);
        chk("out_pb_o",  pb_pad_o,  8'h3C);
        chk("out_pb_oe", pb_pad_oe, 8'h0F);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pa_pad_o",  pa_pad_o,  8'h00);
        chk("arst_pa_pad_oe", pa_pad_oe, 8'h00);
        chk("arst_pb_pad_oe", pb_pad_oe, 8'h00);
        chk("arst_PAI",       PAI,       8'hFF);
        step(2);
        #2 rst_n = 1'b1;
        step(2);

        // Debounce PA3 falling then rising
        pa_pad_i = 8'hF7;
        c0 = cyc;
        expect_chg(c0 + 12, 16'h0008);
        step(11);
        chk("db_pa3_edge11", PAI, 8'hFF);
        step(1);
        chk("db_pa3_edge12", PAI, 8'hF7);
        chk("db_pa3_strobe", chg_strobe, 1'b1);
        chk("db_pa3_mask",   chg_mask, 16'h0008);
        step(1);
        chk("db_pa3_strobe_off", chg_strobe, 1'b0);
        pa_pad_i = 8'hFF;
        expect_chg(cyc + 12, 16'h0008);
        step(12);
        chk("db_pa3_restore", PAI, 8'hFF);
        step(3);

        // Glitch of 9 cycles is rejected
        pa_pad_i = 8'hFE;
        step(9);
        pa_pad_i = 8'hFF;
        step(3);
        chk("glitch9_PAI", PAI, 8'hFF);
        step(12);
        chk("glitch9_PAI_late", PAI, 8'hFF);

        // Pulse of 10 cycles gets through and returns
        pa_pad_i = 8'hFE;
        c0 = cyc;
        expect_chg(c0 + 12, 16'h0001);
        expect_chg(c0 + 22, 16'h0001);
        step(10);
        pa_pad_i = 8'hFF;
        step(1);
        chk("pulse10_edge11", PAI, 8'hFF);
        step(1);
        chk("pulse10_edge12", PAI, 8'hFE);
        step(9);
        chk("pulse10_edge21", PAI, 8'hFE);
        step(1);
        chk("pulse10_edge22", PAI, 8'hFF);
        step(3);

        // Chip-select bypass on PB6 with simultaneous debounced PB0
        pb_pad_i = 8'hBE;
        c0 = cyc;
        expect_chg(c0 + 3,  16'h4000);
        expect_chg(c0 + 12, 16'h0100);
        step(2);
        chk("cs_edge2",  PBI, 8'hFF);
        step(1);
        chk("cs_edge3",  PBI, 8'hBF);
        step(8);
        chk("cs_edge11", PBI, 8'hBF);
        step(1);
        chk("cs_edge12", PBI, 8'hBE);
        pb_pad_i = 8'hFF;
        c0 = cyc;
        expect_chg(c0 + 3,  16'h4000);
        expect_chg(c0 + 12, 16'h0100);
        step(14);
        chk("cs_restore", PBI, 8'hFF);

        // Enter bypass five samples into a count, then leave it
        pa_pad_i = 8'hFD;
        c0 = cyc;
        step(7);
        chk("byp_before", PAI, 8'hFF);
        db_bypass = 1'b1;
        expect_chg(c0 + 8, 16'h0002);
        step(1);
        chk("byp_follow", PAI, 8'hFD);
        db_bypass = 1'b0;
        pa_pad_i  = 8'hFF;
        expect_chg(cyc + 12, 16'h0002);
        step(11);
        chk("byp_exit_edge11", PAI, 8'hFD);
        step(1);
        chk("byp_exit_edge12", PAI, 8'hFF);
        step(3);

        // Reset six samples into a count discards it
        pa_pad_i = 8'hFB;
        step(8);
        chk("rstcnt_before", PAI, 8'hFF);
        #2 rst_n = 1'b0;
        pa_pad_i = 8'hFF;
        #1;
        chk("rstcnt_PAI",    PAI, 8'hFF);
        chk("rstcnt_strobe", chg_strobe, 1'b0);
        step(1);
        #2 rst_n = 1'b1;
        step(20);
        chk("rstcnt_after", PAI, 8'hFF);

        step(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rriot_port_conditioner
`default_nettype wire
